id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding for the 5-stage MIPS pipe.
- Sits directly upstream of the EX-stage ALU and drives its alu_a, alu_b and alu_op.
- Detects load-use hazards, inserts bubbles and honours flush/stall.
- Keeps held operands fresh while EX is stalled, so a forwarded result is never lost.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  RW each  source/destination register numbers
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs/rt
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  DW  already-extended immediate
- id_shamt  in  5  shift amount
- id_alu_op  in  5  ALU op code (shared encoding)
- id_a_sel  in  1  0 = rs, 1 = zero-extended shamt
- id_b_sel  in  1  0 = rt, 1 = imm
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exmem_reg_write  in  1  EX/MEM writeback enable
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM result
- memwb_reg_write  in  1  MEM/WB writeback enable
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB result
- flush  in  1  kill the instruction entering EX
- ex_stall  in  1  downstream stall; hold EX
- alu_a, alu_b  out  DW each  ALU operands, combinational from register + forwarding
- alu_op  out  5  registered op
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control
- ex_rd  out  RW  registered destination
- ex_store_data  out  DW  forwarded rt, for stores
- load_use_stall  out  1  combinational; freezes PC and IF/ID

Behaviour:
- Reset (rst_n = 0, async): every register cleared.
  - ex_valid = 0, alu_op = A_NOP, all control bits 0, ex_rd = 0, stored data 0.
  - Therefore alu_a = alu_b = 0 and load_use_stall = 0.
- Forwarding (per source, combinational, on the registered address/data):
  - if exmem_reg_write and exmem_rd != 0 and exmem_rd == ex_src: use exmem_result;
  - else if memwb_reg_write and memwb_rd != 0 and memwb_rd == ex_src: use memwb_result;
  - else use the registered data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand select:
  - alu_a = a_sel ? {27'b0, shamt} : fwd_rs.
  - alu_b = b_sel ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
- Load-use detection:
  - load_use_stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs & id_rs_addr == ex_rd) | (id_uses_rt & id_rt_addr == ex_rd)).
  - Masked to 0 while ex_stall = 1.
- Register update at posedge clk, in priority order:
  1. ex_stall = 1: hold all fields, but rewrite the rs/rt data registers with fwd_rs/fwd_rt. Flush is not sampled; the hazard unit keeps flush asserted until ex_stall = 0.
  2. flush = 1: load a bubble (valid = 0, alu_op = A_NOP, reg_write = mem_read = mem_write = 0, ex_rd = 0).
  3. load_use_stall = 1: load a bubble.
  4. Otherwise: load all ID fields. If id_valid = 0, load a bubble.
- Latency: one cycle ID→EX. A load result reaches the consumer after exactly one bubble, via MEM/WB forwarding.
- Reset mid-stall: everything clears immediately. No pending state survives.

Decomposition:
- Shared package cpu_pkg holds:
  - the ALU op constants A_NOP=0x00, A_ADD=0x01, A_SUB=0x02, A_AND=0x03, A_OR=0x04, A_XOR=0x05, A_NOR=0x06, A_SLL=0x07, A_SRL=0x08, A_SRA=0x09, A_LUI=0x0a, A_SLT=0x0b, A_SLTU=0x0c, A_DIV=0x0d;
  - DW and RW.
- One sub-module, fwd_mux (3-way priority forwarding select), instantiated twice: once for rs, once for rt.

Test Plan:
- Reset: rst_n low mid-cycle → all outputs go to 0 asynchronously, alu_op = 0x00, ex_valid = 0.
- EX/MEM forward: EX holds add with rs = 3, rs_data = 5; exmem_rd = 3, exmem_result = 0x10, memwb_rd = 3, memwb_result = 0x20 → alu_a = 0x10.
- r0 guard: ex rs = 0, exmem_rd = 0, exmem_reg_write = 1, exmem_result = 0xFFFF → alu_a = registered 0.
- Load-use: EX = lw to r4; ID = add reading r4 via rs → load_use_stall = 1 for one cycle. Next cycle ex_valid = 0 with A_NOP. Following cycle the add enters and alu_a = memwb_result when memwb_rd = 4.
- Stall with refresh: EX holds sub with rt = 7 while ex_stall = 1 for 2 cycles; memwb writes r7 = 0x55 in stall cycle 1, then memwb_rd changes → after release alu_b = 0x55.
- Flush vs stall: flush = 1 with ex_stall = 1 → EX unchanged. After ex_stall drops with flush still 1 → bubble; id fields discarded.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Purpose: Shared definitions for the 5-stage pipe. It holds the datapath and
//          register-address widths and the ALU operation encoding that ID, EX
//          and the ALU all agree on.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DW  = 32;  // datapath width
  localparam int RW  = 5;   // register address width
  localparam int OPW = 5;   // ALU op code width

  typedef logic [OPW-1:0] alu_op_t;

  localparam alu_op_t A_NOP  = 5'h00;
  localparam alu_op_t A_ADD  = 5'h01;
  localparam alu_op_t A_SUB  = 5'h02;
  localparam alu_op_t A_AND  = 5'h03;
  localparam alu_op_t A_OR   = 5'h04;
  localparam alu_op_t A_XOR  = 5'h05;
  localparam alu_op_t A_NOR  = 5'h06;
  localparam alu_op_t A_SLL  = 5'h07;
  localparam alu_op_t A_SRL  = 5'h08;
  localparam alu_op_t A_SRA  = 5'h09;
  localparam alu_op_t A_LUI  = 5'h0a;
  localparam alu_op_t A_SLT  = 5'h0b;
  localparam alu_op_t A_SLTU = 5'h0c;
  localparam alu_op_t A_DIV  = 5'h0d;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module : id_ex_if
// Purpose: Bundle of every signal crossing the ID/EX operand stage boundary.
//          The side that supplies the decoded instruction, the writeback
//          results and the hazard controls is the master. The operand stage
//          is the slave. It returns the ALU operands, the EX controls and the
//          load-use stall.
// Ports  : ID fields (id_*), EX/MEM and MEM/WB writeback (exmem_*, memwb_*),
//          flush / ex_stall, ALU outputs (alu_*), EX controls (ex_*),
//          load_use_stall.
// Rev    : 1.0 - initial release
// ============================================================================
interface id_ex_if #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
);

  // Decoded instruction from ID
  logic          id_valid;
  logic [RW-1:0] id_rs_addr;
  logic [RW-1:0] id_rt_addr;
  logic [RW-1:0] id_rd_addr;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic [4:0]    id_alu_op;
  logic          id_a_sel;
  logic          id_b_sel;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;

  // Writeback results from later stages
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;

  // Hazard controls
  logic          flush;
  logic          ex_stall;

  // EX-stage outputs
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_op;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_store_data;
  logic          load_use_stall;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs,
           id_uses_rt, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op,
           id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
           flush, ex_stall,
    input  alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs,
           id_uses_rt, id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op,
           id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
           flush, ex_stall,
    output alu_a, alu_b, alu_op, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd, ex_store_data, load_use_stall
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module : fwd_mux
// Purpose: Three-way priority forwarding select for one EX source operand.
//          EX/MEM wins over MEM/WB, and register 0 is never forwarded. When
//          neither stage hits, the registered operand passes through.
// Ports  : src_addr_i / reg_data_i            - registered source and its data
//          exmem_reg_write_i/_rd_i/_result_i  - EX/MEM writeback
//          memwb_reg_write_i/_rd_i/_result_i  - MEM/WB writeback
//          fwd_data_o                         - forwarded operand
// Rev    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_addr_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          exmem_reg_write_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [DW-1:0] fwd_data_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr_i);

  always_comb begin
    fwd_data_o = reg_data_i;
    if (exmem_hit) begin
      fwd_data_o = exmem_result_i;
    end else if (memwb_hit) begin
      fwd_data_o = memwb_result_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage
// Purpose: ID/EX pipeline register with EX-side operand forwarding. It feeds
//          alu_a / alu_b / alu_op to the EX-stage ALU, detects load-use
//          hazards, inserts bubbles and honours flush and stall. While EX is
//          stalled, the held rs/rt data is rewritten with the forwarded value,
//          so a result that retires during the stall is not lost.
// Ports  : clk    - pipeline clock
//          rst_n  - asynchronous active-low reset
//          bus    - id_ex_if.slave (ID fields, writeback results, flush,
//                   ex_stall in; ALU operands, EX controls, load_use_stall out)
// Rev    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic    clk,
  input  logic    rst_n,
  id_ex_if.slave  bus
);

  // EX register: current and next state
  logic          valid_q,     valid_d;
  logic [RW-1:0] rs_addr_q,   rs_addr_d;
  logic [RW-1:0] rt_addr_q,   rt_addr_d;
  logic [RW-1:0] rd_q,        rd_d;
  logic [DW-1:0] rs_data_q,   rs_data_d;
  logic [DW-1:0] rt_data_q,   rt_data_d;
  logic [DW-1:0] imm_q,       imm_d;
  logic [4:0]    shamt_q,     shamt_d;
  alu_op_t       alu_op_q,    alu_op_d;
  logic          a_sel_q,     a_sel_d;
  logic          b_sel_q,     b_sel_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q,  mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          rs_dep;
  logic          rt_dep;
  logic          load_use;

  // ---------------------------------------------------------------------------
  // Forwarding, one mux per source operand
  // ---------------------------------------------------------------------------
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_addr_i        (rs_addr_q),
    .reg_data_i        (rs_data_q),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_result_i    (bus.memwb_result),
    .fwd_data_o        (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_addr_i        (rt_addr_q),
    .reg_data_i        (rt_data_q),
    .exmem_reg_write_i (bus.exmem_reg_write),
    .exmem_rd_i        (bus.exmem_rd),
    .exmem_result_i    (bus.exmem_result),
    .memwb_reg_write_i (bus.memwb_reg_write),
    .memwb_rd_i        (bus.memwb_rd),
    .memwb_result_i    (bus.memwb_result),
    .fwd_data_o        (fwd_rt)
  );

  // ---------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose destination is read by the ID
  // instruction. Masked during ex_stall because nothing advances then.
  // ---------------------------------------------------------------------------
  assign rs_dep   = bus.id_uses_rs && (bus.id_rs_addr == rd_q);
  assign rt_dep   = bus.id_uses_rt && (bus.id_rt_addr == rd_q);
  assign load_use = valid_q && mem_read_q && (rd_q != '0) && bus.id_valid &&
                    (rs_dep || rt_dep) && !bus.ex_stall;

  // ---------------------------------------------------------------------------
  // Next-state selection: stall > flush > load-use bubble > load/ID bubble
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d     = valid_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_d        = rd_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    alu_op_d    = alu_op_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    if (bus.ex_stall) begin
      // Hold the instruction, but capture whatever is forwarded right now.
      // The producing stage may retire before the stall releases.
      rs_data_d = fwd_rs;
      rt_data_d = fwd_rt;
    end else if (bus.flush || load_use || !bus.id_valid) begin
      // Bubble. The whole register is cleared, so a dead slot can never
      // match a forwarding address.
      valid_d     = 1'b0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rd_d        = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      shamt_d     = '0;
      alu_op_d    = A_NOP;
      a_sel_d     = 1'b0;
      b_sel_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      valid_d     = 1'b1;
      rs_addr_d   = bus.id_rs_addr;
      rt_addr_d   = bus.id_rt_addr;
      rd_d        = bus.id_rd_addr;
      rs_data_d   = bus.id_rs_data;
      rt_data_d   = bus.id_rt_data;
      imm_d       = bus.id_imm;
      shamt_d     = bus.id_shamt;
      alu_op_d    = bus.id_alu_op;
      a_sel_d     = bus.id_a_sel;
      b_sel_d     = bus.id_b_sel;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
      mem_write_d = bus.id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      alu_op_q    <= A_NOP;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      alu_op_q    <= alu_op_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.alu_a          = a_sel_q ? {{(DW-5){1'b0}}, shamt_q} : fwd_rs;
  assign bus.alu_b          = b_sel_q ? imm_q : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.alu_op         = alu_op_q;
  assign bus.ex_valid       = valid_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_mem_read    = mem_read_q;
  assign bus.ex_mem_write   = mem_write_q;
  assign bus.ex_rd          = rd_q;
  assign bus.load_use_stall = load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_operand_stage
// Purpose: Self-checking bench for id_ex_operand_stage. A vector table covers
//          forwarding and operand selection. Hand-written sequences cover
//          reset, load-use, stall refresh, flush-vs-stall and reset mid-stall.
// Ports  : none
// Rev    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  shamt;
    logic [4:0]  op;
    logic        a_sel, b_sel, rw, mr, mw;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.id_valid = 0;        bus.id_rs_addr = 0;      bus.id_rt_addr = 0;
    bus.id_rd_addr = 0;      bus.id_uses_rs = 0;      bus.id_uses_rt = 0;
    bus.id_rs_data = 0;      bus.id_rt_data = 0;      bus.id_imm = 0;
    bus.id_shamt = 0;        bus.id_alu_op = 0;       bus.id_a_sel = 0;
    bus.id_b_sel = 0;        bus.id_reg_write = 0;    bus.id_mem_read = 0;
    bus.id_mem_write = 0;    bus.exmem_reg_write = 0; bus.exmem_rd = 0;
    bus.exmem_result = 0;    bus.memwb_reg_write = 0; bus.memwb_rd = 0;
    bus.memwb_result = 0;    bus.flush = 0;           bus.ex_stall = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic [4:0] op, input logic rw, input logic mr, input logic mw);
    bus.id_valid = 1;   bus.id_rs_addr = rs;  bus.id_rt_addr = rt;  bus.id_rd_addr = rd;
    bus.id_uses_rs = 1; bus.id_uses_rt = 1;   bus.id_rs_data = rs_d; bus.id_rt_data = rt_d;
    bus.id_alu_op = op; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_a_sel = 0;   bus.id_b_sel = 0;     bus.id_imm = 0;       bus.id_shamt = 0;
  endtask

  initial begin
    vec_t v;
    //          rs    rt    rd    rs_d          rt_d   imm           sh     op     as bs rw mr mw  exwe exrd  exres        wbwe wbrd  wbres        exp_a        exp_b          exp_st
    vecs[0] = '{5'd3, 5'd2, 5'd5, 32'h5,        32'h9, 32'h0,        5'd0,  A_ADD, 0, 0, 1, 0, 0, 1, 5'd3,  32'h10,      1, 5'd3,  32'h20,      32'h10,      32'h9,         32'h9};
    vecs[1] = '{5'd0, 5'd0, 5'd1, 32'h0,        32'h0, 32'h0,        5'd0,  A_ADD, 0, 0, 1, 0, 0, 1, 5'd0,  32'hFFFF,    1, 5'd0,  32'h1234,    32'h0,       32'h0,         32'h0};
    vecs[2] = '{5'd4, 5'd6, 5'd2, 32'h1,        32'h2, 32'h0,        5'd0,  A_SUB, 0, 0, 1, 0, 0, 1, 5'd7,  32'hAA,      1, 5'd6,  32'h77,      32'h1,       32'h77,        32'h77};
    vecs[3] = '{5'd8, 5'd8, 5'd3, 32'h11,       32'h11, 32'h0,       5'd0,  A_OR,  0, 0, 1, 0, 0, 0, 5'd8,  32'hBAD,     0, 5'd8,  32'hBEEF,    32'h11,      32'h11,        32'h11};
    vecs[4] = '{5'd1, 5'd2, 5'd9, 32'hDEAD,     32'h22, 32'hFFFF_FFF0, 5'd31, A_SLL, 1, 1, 1, 0, 0, 1, 5'd2,  32'h99,      0, 5'd0,  32'h0,       32'h1F,      32'hFFFF_FFF0, 32'h99};
    vecs[5] = '{5'd9, 5'd10, 5'd11, 32'h1,      32'h2, 32'h0,        5'd0,  A_XOR, 0, 0, 0, 0, 1, 1, 5'd10, 32'h100,     1, 5'd9,  32'h200,     32'h200,     32'h100,       32'h100};
    vecs[6] = '{5'd11, 5'd12, 5'd12, 32'h1000,  32'h5, 32'h4,        5'd0,  A_ADD, 0, 1, 1, 1, 0, 0, 5'd0,  32'h0,       1, 5'd11, 32'h2000,    32'h2000,    32'h4,         32'h5};

    // ---------------- reset state ----------------
    rst_n = 0;
    clr_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_alu_op", bus.alu_op, A_NOP);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_ex_rd", bus.ex_rd, 0);
    check("rst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    check("rst_lus", bus.load_use_stall, 0);
    rst_n = 1;

    // ---------------- table-driven forwarding / select ----------------
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      clr_inputs();
      v = vecs[i];
      set_id(v.rs, v.rt, v.rd, v.rs_d, v.rt_d, v.op, v.rw, v.mr, v.mw);
      bus.id_imm = v.imm; bus.id_shamt = v.shamt;
      bus.id_a_sel = v.a_sel; bus.id_b_sel = v.b_sel;
      sb.push_back(v);
      @(posedge clk); #1;
      bus.id_valid = 0;
      bus.exmem_reg_write = sb[0].ex_we; bus.exmem_rd = sb[0].ex_rd; bus.exmem_result = sb[0].ex_res;
      bus.memwb_reg_write = sb[0].wb_we; bus.memwb_rd = sb[0].wb_rd; bus.memwb_result = sb[0].wb_res;
      @(negedge clk);
      v = sb.pop_front();
      check($sformatf("v%0d_alu_a", i), bus.alu_a, v.exp_a);
      check($sformatf("v%0d_alu_b", i), bus.alu_b, v.exp_b);
      check($sformatf("v%0d_store", i), bus.ex_store_data, v.exp_st);
      check($sformatf("v%0d_alu_op", i), bus.alu_op, v.op);
      check($sformatf("v%0d_ex_rd", i), bus.ex_rd, v.rd);
      check($sformatf("v%0d_valid", i), bus.ex_valid, 1);
      check($sformatf("v%0d_ctrl", i), {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
            {v.rw, v.mr, v.mw});
      check($sformatf("v%0d_lus", i), bus.load_use_stall, 0);
    end

    // ---------------- load-use: one bubble, then MEM/WB forward ----------------
    @(posedge clk); #1;
    clr_inputs();
    set_id(5'd1, 5'd4, 5'd4, 32'h0, 32'h0, A_ADD, 1, 1, 0);   // lw r4
    bus.id_b_sel = 1; bus.id_imm = 32'h8; bus.id_uses_rt = 0;
    @(posedge clk); #1;
    set_id(5'd4, 5'd0, 5'd6, 32'h0BAD, 32'h0, A_ADD, 1, 0, 0); // add r6 <- r4
    @(negedge clk);
    check("lu_stall_asserted", bus.load_use_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("lu_bubble_valid", bus.ex_valid, 0);
    check("lu_bubble_op", bus.alu_op, A_NOP);
    check("lu_stall_released", bus.load_use_stall, 0);
    @(posedge clk); #1;
    bus.id_valid = 0;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd4; bus.memwb_result = 32'hCAFE;
    bus.exmem_reg_write = 1; bus.exmem_rd = 5'd9; bus.exmem_result = 32'h1;
    @(negedge clk);
    check("lu_consumer_valid", bus.ex_valid, 1);
    check("lu_consumer_op", bus.alu_op, A_ADD);
    check("lu_consumer_alu_a", bus.alu_a, 32'hCAFE);
    check("lu_consumer_rd", bus.ex_rd, 6);

    // ---------------- stall with operand refresh ----------------
    @(posedge clk); #1;
    clr_inputs();
    set_id(5'd2, 5'd7, 5'd8, 32'h3, 32'h1, A_SUB, 1, 0, 0);
    @(posedge clk); #1;
    bus.ex_stall = 1;
    set_id(5'd1, 5'd1, 5'd9, 32'h0, 32'h0, A_ADD, 1, 0, 0);
    bus.memwb_reg_write = 1; bus.memwb_rd = 5'd7; bus.memwb_result = 32'h55;
    @(negedge clk);
    check("stall1_alu_b", bus.alu_b, 32'h55);
    check("stall1_ex_rd", bus.ex_rd, 8);
    @(posedge clk); #1;
    bus.memwb_rd = 5'd9; bus.memwb_result = 32'h66;
    @(negedge clk);
    check("stall2_alu_b", bus.alu_b, 32'h55);
    check("stall2_alu_op", bus.alu_op, A_SUB);
    check("stall2_store", bus.ex_store_data, 32'h55);
    @(posedge clk); #1;
    bus.ex_stall = 0; bus.memwb_reg_write = 0;
    @(negedge clk);
    check("release_alu_b", bus.alu_b, 32'h55);
    check("release_alu_op", bus.alu_op, A_SUB);
    check("release_ex_rd", bus.ex_rd, 8);
    @(posedge clk); #1;
    bus.id_valid = 0;
    @(negedge clk);
    check("after_release_op", bus.alu_op, A_ADD);
    check("after_release_rd", bus.ex_rd, 9);

    // ---------------- flush vs stall ----------------
    @(posedge clk); #1;
    clr_inputs();
    set_id(5'd1, 5'd4, 5'd4, 32'h0, 32'h0, A_ADD, 1, 1, 0);    // lw r4
    bus.id_b_sel = 1; bus.id_uses_rt = 0;
    @(posedge clk); #1;
    bus.ex_stall = 1; bus.flush = 1;
    set_id(5'd4, 5'd0, 5'd10, 32'h0, 32'h0, A_OR, 1, 0, 0);    // reads r4
    @(negedge clk);
    check("fs_lus_masked", bus.load_use_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fs_hold_valid", bus.ex_valid, 1);
    check("fs_hold_op", bus.alu_op, A_ADD);
    check("fs_hold_rd", bus.ex_rd, 4);
    check("fs_hold_mr", bus.ex_mem_read, 1);
    @(posedge clk); #1;
    bus.ex_stall = 0;
    @(negedge clk);
    check("fs_lus_unmasked", bus.load_use_stall, 1);
    check("fs_still_rd", bus.ex_rd, 4);
    @(posedge clk); #1;
    bus.flush = 0; bus.id_valid = 0;
    @(negedge clk);
    check("fs_bubble_valid", bus.ex_valid, 0);
    check("fs_bubble_op", bus.alu_op, A_NOP);
    check("fs_bubble_rd", bus.ex_rd, 0);
    check("fs_bubble_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);

    // ---------------- asynchronous reset mid-stall ----------------
    @(posedge clk); #1;
    clr_inputs();
    set_id(5'd5, 5'd6, 5'd7, 32'h123, 32'h456, A_AND, 1, 0, 1);
    @(posedge clk); #1;
    bus.ex_stall = 1; bus.id_valid = 0;
    @(negedge clk);
    check("pre_rst_valid", bus.ex_valid, 1);
    check("pre_rst_alu_a", bus.alu_a, 32'h123);
    #2;
    rst_n = 0;
    #1;
    check("arst_valid", bus.ex_valid, 0);
    check("arst_op", bus.alu_op, A_NOP);
    check("arst_alu_a", bus.alu_a, 0);
    check("arst_alu_b", bus.alu_b, 0);
    check("arst_store", bus.ex_store_data, 0);
    check("arst_rd", bus.ex_rd, 0);
    check("arst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    @(posedge clk); #1;
    bus.ex_stall = 0;
    rst_n = 1;
    @(negedge clk);
    check("post_rst_valid", bus.ex_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
